// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_fetch_pkg
//  Description : Shared constants for the instruction fetch stage: FSM state
//                encoding, the NOP word loaded on reset and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_fetch_pkg;

    localparam int INST_WIDTH = 32;

    // Fetch FSM state encoding
    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    // addi x0, x0, 0
    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : riscv_fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_unit_pc_register.sv
`default_nettype none
// ============================================================================
//  Module      : pc_register
//  Description : Program counter with synchronous reset, load enable and the
//                next-PC mux (PC+4 or word-aligned branch/jump target).
//  Ports       : clk, rst            - clock, sync active-high reset
//                i_load              - update the PC on this edge
//                i_sel_target        - 1: take aligned target, 0: take PC+4
//                i_target            - branch/jump target
//                o_pc, o_pc_plus4    - current PC and PC+4 (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_register
    import riscv_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_sel_target,
    input  logic [XLEN-1:0] i_target,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4
);

    // Low two bits of a target are dropped: no misalignment trap exists.
    localparam logic [XLEN-1:0] c_align_mask = {{(XLEN-2){1'b0}}, 2'b11};

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_next_pc;

    // Wraps modulo 2^XLEN naturally.
    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_next_pc  = i_sel_target ? (i_target & ~c_align_mask) : w_pc_plus4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= w_next_pc;
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = w_pc_plus4;

endmodule : pc_register
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit
//  Description : Fetch stage. Requests the word at PC over a REQ/ACK
//                handshake, holds it for the consumer, then advances the PC to
//                PC+4 or to the ALU target once the instruction retires.
//  Ports       : CLK, RST                       - clock, sync active-high reset
//                PCsel_IF, ALU_TARGET_IF        - next-PC select and target
//                INST_READY_IF                  - consumer retired instruction
//                IMEM_REQ_IF/ADDR_IF/ACK_IF/RDATA_IF - instruction memory port
//                INST_IF, INST_VALID_IF         - held instruction and valid
//                PC_IF, PC_PLUS4_IF             - current PC and PC+4
//                INSTRET_IF                     - retired instruction count
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            PCsel_IF,
    input  logic [XLEN-1:0] ALU_TARGET_IF,
    input  logic            INST_READY_IF,
    output logic            IMEM_REQ_IF,
    output logic [XLEN-1:0] IMEM_ADDR_IF,
    input  logic            IMEM_ACK_IF,
    input  logic [XLEN-1:0] IMEM_RDATA_IF,
    output logic [XLEN-1:0] INST_IF,
    output logic            INST_VALID_IF,
    output logic [XLEN-1:0] PC_IF,
    output logic [XLEN-1:0] PC_PLUS4_IF,
    output logic [31:0]     INSTRET_IF
);

    logic [0:0]      r_state;
    logic [0:0]      w_next_state;
    logic            w_capture;
    logic            w_retire;
    logic            w_req;
    logic [XLEN-1:0] r_inst;
    logic            r_valid;
    logic [31:0]     r_instret;
    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_pc_plus4;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH:   if (IMEM_ACK_IF)   w_next_state = HOLD;
            HOLD:    if (INST_READY_IF) w_next_state = FETCH;
            default: w_next_state = FETCH;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // ACK in HOLD and READY in FETCH are decoded away here, so stray
    // handshakes cannot disturb the held instruction or the PC.
    always_comb begin
        w_req     = 1'b0;
        w_capture = 1'b0;
        w_retire  = 1'b0;
        case (r_state)
            FETCH: begin
                w_req     = ~RST;
                w_capture = IMEM_ACK_IF;
            end
            HOLD: begin
                w_retire  = INST_READY_IF;
            end
            default: ;
        endcase
    end

    // ---------------- Instruction holding register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_inst    <= XLEN'(NOP_INST);
            r_valid   <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            if (w_capture) begin
                r_inst  <= IMEM_RDATA_IF;
                r_valid <= 1'b1;
            end else if (w_retire) begin
                r_valid <= 1'b0;
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    // ---------------- Program counter ----------------
    pc_register #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk          (CLK),
        .rst          (RST),
        .i_load       (w_retire),
        .i_sel_target (PCsel_IF),
        .i_target     (ALU_TARGET_IF),
        .o_pc         (w_pc),
        .o_pc_plus4   (w_pc_plus4)
    );

    assign IMEM_REQ_IF   = w_req;
    assign IMEM_ADDR_IF  = w_pc;
    assign INST_IF       = r_inst;
    assign INST_VALID_IF = r_valid;
    assign PC_IF         = w_pc;
    assign PC_PLUS4_IF   = w_pc_plus4;
    assign INSTRET_IF    = r_instret;

endmodule : instruction_fetch_unit
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_unit
//  Description : Self-checking bench for instruction_fetch_unit. A table of
//                per-cycle input/expected-output records followed by directed
//                sequences for stalls, reset mid-fetch and PC wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        pcsel;
    logic [31:0] target;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] inst;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instret;

    int n_cmp;
    int n_fail;

    instruction_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
        .PCsel_IF      (pcsel),
        .ALU_TARGET_IF (target),
        .INST_READY_IF (ready),
        .IMEM_REQ_IF   (req),
        .IMEM_ADDR_IF  (addr),
        .IMEM_ACK_IF   (ack),
        .IMEM_RDATA_IF (rdata),
        .INST_IF       (inst),
        .INST_VALID_IF (valid),
        .PC_IF         (pc),
        .PC_PLUS4_IF   (pc_plus4),
        .INSTRET_IF    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        pcsel;
        logic [31:0] target;
        logic        e_req;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_valid;
        logic [31:0] e_instret;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Apply inputs just after a rising edge; outputs are then checked
    // mid-cycle, before the next edge.
    task automatic drive(input logic r, input logic a, input logic [31:0] d,
                         input logic rd, input logic ps, input logic [31:0] t);
        @(posedge clk);
        #1;
        rst = r; ack = a; rdata = d; ready = rd; pcsel = ps; target = t;
        #3;
    endtask

    task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_pc,
                             input logic [31:0] e_inst, input logic e_valid,
                             input logic [31:0] e_instret);
        check({tag, ".req"},     {31'd0, req},   {31'd0, e_req});
        check({tag, ".addr"},    addr,           e_pc);
        check({tag, ".pc"},      pc,             e_pc);
        check({tag, ".pc4"},     pc_plus4,       e_pc + 32'd4);
        check({tag, ".inst"},    inst,           e_inst);
        check({tag, ".valid"},   {31'd0, valid}, {31'd0, e_valid});
        check({tag, ".instret"}, instret,        e_instret);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; ack = 1'b0; rdata = 32'd0; ready = 1'b0; pcsel = 1'b0; target = 32'd0;

        //           rst   ack   rdata         rdy   psel  target        req   pc            inst          vld   instret
        vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        c_nop,        1'b0, 32'd0};
        vecs[1]  = '{1'b0, 1'b1, 32'h000002B3, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        c_nop,        1'b0, 32'd0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h000002B3, 1'b1, 32'd0};
        vecs[3]  = '{1'b0, 1'b1, 32'h00100313, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        32'h000002B3, 1'b0, 32'd1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00000043, 1'b0, 32'h4,        32'h00100313, 1'b1, 32'd1};
        // READY (with a jump request) while fetching must be ignored
        vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00000100, 1'b1, 32'h40,       32'h00100313, 1'b0, 32'd2};
        vecs[6]  = '{1'b0, 1'b1, 32'hAAAA0001, 1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       32'h00100313, 1'b0, 32'd2};
        // ACK while holding must be ignored
        vecs[7]  = '{1'b0, 1'b1, 32'hBBBB0002, 1'b0, 1'b0, 32'h0,        1'b0, 32'h40,       32'hAAAA0001, 1'b1, 32'd2};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h40,       32'hAAAA0001, 1'b1, 32'd2};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h40,       32'hAAAA0001, 1'b1, 32'd2};
        vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h44,       32'hAAAA0001, 1'b0, 32'd3};

        @(posedge clk);
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].pcsel, vecs[i].target);
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_pc, vecs[i].e_inst,
                      vecs[i].e_valid, vecs[i].e_instret);
        end

        // ---- ACK delayed: REQ and address held until the 5th cycle ----
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'hDEAD0000, 1'b0, 1'b0, 32'h0);
            check_all($sformatf("stall_ack%0d", i), 1'b1, 32'h44, 32'hAAAA0001, 1'b0, 32'd3);
        end
        drive(1'b0, 1'b1, 32'hCCCC0003, 1'b0, 1'b0, 32'h0);
        check_all("ack5", 1'b1, 32'h44, 32'hAAAA0001, 1'b0, 32'd3);

        // ---- READY delayed three cycles: instruction and PC held ----
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0800);
            check_all($sformatf("stall_rdy%0d", i), 1'b0, 32'h44, 32'hCCCC0003, 1'b1, 32'd3);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check_all("rdy4", 1'b0, 32'h44, 32'hCCCC0003, 1'b1, 32'd3);

        // ---- Reset while a request is pending (ACK during RST ignored) ----
        drive(1'b1, 1'b1, 32'hEEEE0004, 1'b0, 1'b0, 32'h0);
        check_all("rst_pend", 1'b0, 32'h48, 32'hCCCC0003, 1'b0, 32'd4);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_all("after_rst", 1'b1, 32'h0, c_nop, 1'b0, 32'd0);

        // ---- Jump to the top word, then PC+4 wraps to zero ----
        drive(1'b0, 1'b1, 32'h11110005, 1'b0, 1'b0, 32'h0);
        check_all("wrap_f0", 1'b1, 32'h0, c_nop, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        check_all("wrap_h0", 1'b0, 32'h0, 32'h11110005, 1'b1, 32'd0);
        drive(1'b0, 1'b1, 32'h22220006, 1'b0, 1'b0, 32'h0);
        check_all("wrap_f1", 1'b1, 32'hFFFF_FFFC, 32'h11110005, 1'b0, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check_all("wrap_h1", 1'b0, 32'hFFFF_FFFC, 32'h22220006, 1'b1, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_all("wrap_f2", 1'b1, 32'h0, 32'h22220006, 1'b0, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_instruction_fetch_unit
`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage of the RISC-V core. It sits directly upstream of CONTROL_UNIT and the datapath.
- Holds the PC and requests instructions from instruction memory over a REQ/ACK handshake.
- Presents the fetched word on INST_IF, which drives INST_CTRL.
- Advances the PC to PC+4, or to the ALU target when PCsel is high, once the consumer accepts the instruction.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
XLEN, 32, address and instruction width.

Ports:
CLK  in  1  core clock; all state updates on the rising edge.
RST  in  1  reset, synchronous, active-high.
PCsel_IF  in  1  from PCsel_CTRL; 1 = next PC is ALU_TARGET_IF, 0 = PC+4.
ALU_TARGET_IF  in  XLEN  branch/jump target from the ALU.
INST_READY_IF  in  1  consumer has executed the held instruction.
IMEM_REQ_IF  out  1  instruction memory read request.
IMEM_ADDR_IF  out  XLEN  read address; always equals PC_IF.
IMEM_ACK_IF  in  1  memory returns data this cycle.
IMEM_RDATA_IF  in  XLEN  instruction word; valid when ACK=1.
INST_IF  out  XLEN  held instruction, to INST_CTRL.
INST_VALID_IF  out  1  INST_IF holds a fetched instruction.
PC_IF  out  XLEN  address of the current or held instruction.
PC_PLUS4_IF  out  XLEN  PC_IF+4, for the write-back mux.
INSTRET_IF  out  32  count of retired instructions.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high; it is sampled on the CLK edge and overrides every other input.
- Reset values:
  - PC_IF = RESET_PC.
  - INST_IF = 32'h00000013 (NOP).
  - INST_VALID_IF = 0, IMEM_REQ_IF = 0, INSTRET_IF = 0.
  - State = FETCH.
- States: FETCH, HOLD.
- FETCH:
  - IMEM_REQ_IF = 1 (forced 0 while RST=1); address = PC_IF, stable until ACK.
  - On ACK=1: capture IMEM_RDATA_IF into INST_IF, set INST_VALID_IF = 1 next cycle, go to HOLD.
  - ACK may arrive in the same cycle REQ first rises. Minimum fetch latency is 1 cycle; there is no maximum and no timeout.
- HOLD:
  - IMEM_REQ_IF = 0; INST_IF, PC_IF and INST_VALID_IF are held stable.
  - On INST_READY_IF = 1, at the edge:
    - PC_IF becomes {ALU_TARGET_IF[XLEN-1:2], 2'b00} if PCsel_IF = 1, else PC_IF + 4.
    - INSTRET_IF increments.
    - INST_VALID_IF goes to 0; next state is FETCH.
  - PCsel_IF and ALU_TARGET_IF are sampled only in HOLD with READY = 1 and ignored otherwise.
- Throughput: 2 cycles per instruction minimum (FETCH with immediate ACK, then HOLD with immediate READY).
- Arithmetic:
  - PC+4 wraps modulo 2^XLEN (32'hFFFFFFFC + 4 = 0).
  - INSTRET_IF wraps modulo 2^32.
  - Target bits [1:0] are silently cleared; there is no misalignment trap.
- Spurious handshakes:
  - ACK in HOLD is ignored.
  - READY in FETCH is ignored.
- Reset mid-operation: RST during FETCH with a pending request, or during HOLD, returns to reset values on that edge. Memory must abandon any pending request when REQ drops; an ACK seen while RST=1 is ignored.
- PC_PLUS4_IF is combinational from PC_IF.

Decomposition:
- Package riscv_fetch_pkg:
  - state encoding FETCH = 1'b0, HOLD = 1'b1;
  - NOP_INST = 32'h00000013;
  - DEFAULT_RESET_PC;
  - INST_WIDTH = 32.
- One sub-module is natural: pc_register. It holds the PC with sync reset to RESET_PC, a load enable, and the next-PC mux (PC+4 or aligned target).

Test Plan:
1. Reset, then ACK in the first REQ cycle with RDATA = 32'h000002B3 -> IMEM_ADDR_IF = 0; next cycle INST_IF = 32'h000002B3, INST_VALID_IF = 1, PC_IF = 0.
2. Continue from 1 with READY = 1, PCsel = 0, then ACK with 32'h00100313 -> IMEM_ADDR_IF = 4, INST_IF = 32'h00100313, INSTRET_IF = 1, PC_PLUS4_IF = 8.
3. In HOLD, drive READY = 1, PCsel = 1, ALU_TARGET = 32'h00000043 -> next IMEM_ADDR_IF = 32'h00000040.
4. Delay ACK 5 cycles -> REQ stays high and the address stable for all 5; INST_VALID_IF = 0 throughout; the word is captured on the 5th cycle. Delay READY 3 cycles -> INST_IF and PC_IF stay unchanged.
5. Assert RST for 1 cycle while REQ is pending at PC = 8 -> next cycle PC_IF = RESET_PC, INST_IF = NOP, INSTRET_IF = 0, REQ = 0 during RST, REQ = 1 after.
6. Set PC = 32'hFFFFFFFC by jump, then retire with PCsel = 0 -> PC_IF wraps to 0.
